// File: rtl/fos_out_decim.sv
// fos_out_decim: boxcar decimator for the IIR section's y_out.
// Sums 2^DECIM_LOG2 accepted samples, rounds (half toward +inf), shifts,
// saturates to OUT_W bits and queues results in a small first-word-fall-through
// FIFO drained through a valid/ready handshake. Sticky sat/ovf flags.
// Optional macro FOS_DECIM_DROP_CNT_EN adds a saturating 16-bit drop counter.
module fos_out_decim #(
  parameter int IN_W       = 32,
  parameter int OUT_W      = 16,
  parameter int DECIM_LOG2 = 2,
  parameter int FRAC_SHIFT = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [IN_W-1:0]               y_in,
  input  logic                          in_en,
  output logic [OUT_W-1:0]              dout,
  output logic                          dout_valid,
  input  logic                          dout_ready,
  output logic                          sat_flag,
  output logic                          ovf_flag,
  input  logic                          clr_flags,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef FOS_DECIM_DROP_CNT_EN
  ,
  output logic [15:0]                   drop_cnt
`endif
);

  localparam int ACC_W = IN_W + DECIM_LOG2;
  localparam int S     = DECIM_LOG2 + FRAC_SHIFT;
  localparam int RW    = ACC_W + 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LW    = AW + 1;

  localparam logic        [RW-1:0] HALF = {{(RW-1){1'b0}}, 1'b1} << (S - 1);
  localparam logic signed [RW-1:0] MAXV = {{(RW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [RW-1:0] MINV = {{(RW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [ACC_W-1:0] r_acc;
  logic [DECIM_LOG2-1:0]   r_cnt;
  logic [OUT_W-1:0]        r_res;
  logic                    r_res_vld;
  logic [OUT_W-1:0]        r_mem [FIFO_DEPTH];
  logic [AW-1:0]           r_wptr;
  logic [AW-1:0]           r_rptr;
  logic [LW-1:0]           r_level;
  logic [OUT_W-1:0]        r_last;
  logic                    r_sat;
  logic                    r_ovf;

  logic signed [ACC_W-1:0] w_y_ext;
  logic signed [ACC_W-1:0] w_total;
  logic signed [RW-1:0]    w_biased;
  logic signed [RW-1:0]    w_r;
  logic                    w_hi;
  logic                    w_lo;
  logic [OUT_W-1:0]        w_clip;
  logic                    w_last;
  logic                    w_full;
  logic                    w_pop;
  logic                    w_wr;
  logic                    w_drop;

  // Result datapath: sign-extend, final sum, round, shift and clip.
  assign w_y_ext  = {{DECIM_LOG2{y_in[IN_W-1]}}, y_in};
  assign w_total  = r_acc + w_y_ext;
  assign w_biased = {w_total[ACC_W-1], w_total} + HALF;
  assign w_r      = w_biased >>> S;
  assign w_hi     = (w_r > MAXV);
  assign w_lo     = (w_r < MINV);
  assign w_clip   = w_hi ? {1'b0, {(OUT_W-1){1'b1}}} :
                    w_lo ? {1'b1, {(OUT_W-1){1'b0}}} : w_r[OUT_W-1:0];
  assign w_last   = in_en && (r_cnt == {DECIM_LOG2{1'b1}});

  // FIFO handshake: a push into a full FIFO only succeeds when a pop frees the slot.
  assign w_full     = (r_level == LW'(FIFO_DEPTH));
  assign w_pop      = (r_level != '0) && dout_ready;
  assign w_wr       = r_res_vld && (!w_full || w_pop);
  assign w_drop     = r_res_vld && w_full && !w_pop;
  assign dout_valid = (r_level != '0);
  assign dout       = (r_level != '0) ? r_mem[r_rptr] : r_last;
  assign fifo_level = r_level;
  assign sat_flag   = r_sat;
  assign ovf_flag   = r_ovf;

  // Accumulate samples; on the last sample of a block register the clipped result.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_acc     <= '0;
      r_cnt     <= '0;
      r_res     <= '0;
      r_res_vld <= 1'b0;
    end else begin
      if (in_en) begin
        if (w_last) begin
          r_acc <= '0;
          r_cnt <= '0;
        end else begin
          r_acc <= w_total;
          r_cnt <= r_cnt + 1'b1;
        end
      end
      r_res_vld <= w_last;
      if (w_last) r_res <= w_clip;
    end
  end

  // FIFO storage; not reset, occupancy is tracked by the pointers/level.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= r_res;
  end

  // FIFO pointers, occupancy and the held output value for the empty case.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_last  <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
        r_last <= r_mem[r_rptr];
      end
      if (w_wr && !w_pop)      r_level <= r_level + 1'b1;
      else if (!w_wr && w_pop) r_level <= r_level - 1'b1;
    end
  end

  // Sticky flags; a set event on the same edge beats clr_flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sat <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      if (w_last && (w_hi || w_lo)) r_sat <= 1'b1;
      else if (clr_flags)           r_sat <= 1'b0;
      if (w_drop)                   r_ovf <= 1'b1;
      else if (clr_flags)           r_ovf <= 1'b0;
    end
  end

`ifdef FOS_DECIM_DROP_CNT_EN
  logic [15:0] r_drop_cnt;
  assign drop_cnt = r_drop_cnt;

  // Saturating count of dropped results; a drop alongside clr_flags restarts at 1.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      if (clr_flags)                r_drop_cnt <= 16'd1;
      else if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
    end else if (clr_flags) begin
      r_drop_cnt <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_fos_out_decim.sv
// Testbench for fos_out_decim: directed scenarios plus randomized traffic,
// checked by a scoreboard queue fed from a behavioural model of the decimator.
module tb_fos_out_decim;

  localparam int NS    = 4;      // samples per block
  localparam int SH    = 2;      // total right shift
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] y_in;
  logic        in_en;
  logic [15:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        sat_flag;
  logic        ovf_flag;
  logic        clr_flags;
  logic [2:0]  fifo_level;
`ifdef FOS_DECIM_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  always #5 clk = ~clk;

  fos_out_decim dut (
    .clk        (clk),
    .reset      (reset),
    .y_in       (y_in),
    .in_en      (in_en),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .sat_flag   (sat_flag),
    .ovf_flag   (ovf_flag),
    .clr_flags  (clr_flags),
    .fifo_level (fifo_level)
`ifdef FOS_DECIM_DROP_CNT_EN
    ,
    .drop_cnt   (drop_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int     exp_q[$];
  int     m_level = 0;
  bit     m_sat = 0, m_ovf = 0;
  int     m_drops = 0;
  longint blk_sum = 0;
  int     blk_n = 0;
  bit     m_pend_vld = 0;
  int     m_pend = 0;
  bit     mon_en = 0;
  int     last_out = 0;

  task automatic chk(input string nm, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Average of a block: floor((sum + d/2) / d) with d = 2^SH, then clip to 16 bits.
  function automatic int ref_result(input longint sum, output bit clipped);
    longint d, t, q;
    d = 1;
    repeat (SH) d = d * 2;
    t = sum + d / 2;
    q = t / d;
    if ((t % d) != 0 && t < 0) q = q - 1;
    clipped = 1'b0;
    if (q > 32767)  begin q = 32767;  clipped = 1'b1; end
    if (q < -32768) begin q = -32768; clipped = 1'b1; end
    return int'(q);
  endfunction

  // Apply one clock of stimulus and advance the model across that edge.
  task automatic step(input logic en, input logic [31:0] y);
    int nl, n_pend, n_cnt, n_drops;
    bit pop, push, drop, sat_set, clip, n_pv, n_sat, n_ovf, rst_now;
    longint n_sum;
    in_en = en;
    y_in  = y;
    rst_now = !reset;
    n_sum = blk_sum; n_cnt = blk_n; n_pend = m_pend;
    n_pv = 0; push = 0; drop = 0; sat_set = 0; pop = 0;
    nl = m_level; n_sat = m_sat; n_ovf = m_ovf; n_drops = m_drops;
    if (rst_now) begin
      nl = 0; n_sum = 0; n_cnt = 0; n_sat = 0; n_ovf = 0; n_drops = 0;
    end else begin
      pop = (m_level > 0) && dout_ready;
      if (m_pend_vld) begin
        if (m_level < DEPTH || pop) begin push = 1; nl++; end
        else drop = 1;
      end
      if (pop) nl--;
      if (en) begin
        n_sum += longint'($signed(y));
        n_cnt++;
        if (n_cnt == NS) begin
          n_pend = ref_result(n_sum, clip);
          sat_set = clip;
          n_pv = 1; n_sum = 0; n_cnt = 0;
        end
      end
      n_sat = sat_set ? 1'b1 : (clr_flags ? 1'b0 : m_sat);
      n_ovf = drop ? 1'b1 : (clr_flags ? 1'b0 : m_ovf);
      if (drop) n_drops = clr_flags ? 1 : ((m_drops >= 65535) ? 65535 : m_drops + 1);
      else      n_drops = clr_flags ? 0 : m_drops;
    end
    @(posedge clk);
    if (rst_now) exp_q.delete();
    else if (push) exp_q.push_back(m_pend);
    m_level = nl; m_sat = n_sat; m_ovf = n_ovf; m_drops = n_drops;
    blk_sum = n_sum; blk_n = n_cnt; m_pend_vld = n_pv; m_pend = n_pend;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0);
  endtask

  task automatic block4(input logic [31:0] v);
    for (int i = 0; i < NS; i++) step(1'b1, v);
  endtask

  // Monitor: compares status every cycle and pops the scoreboard on each handshake.
  initial begin
    int e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("dout_valid", dout_valid, m_level > 0);
        chk("fifo_level", fifo_level, m_level);
        chk("sat_flag", sat_flag, m_sat);
        chk("ovf_flag", ovf_flag, m_ovf);
`ifdef FOS_DECIM_DROP_CNT_EN
        chk("drop_cnt", drop_cnt, m_drops);
`endif
        if (!reset) begin
          last_out = 0;
        end else if (dout_valid && dout_ready) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL pop_unexpected: got %0d expected no output", $signed(dout));
          end else begin
            e = exp_q.pop_front();
            chk("dout", $signed(dout), e);
            $display("pop dout=%0d expected=%0d level=%0d", $signed(dout), e, fifo_level);
            last_out = e;
          end
        end else if (!dout_valid) begin
          chk("dout_hold", $signed(dout), last_out);
        end
      end
    end
  end

  initial begin
    reset = 1'b0; in_en = 1'b0; y_in = '0; dout_ready = 1'b1; clr_flags = 1'b0;
    idle(2);
    reset = 1'b1;
    chk("reset_dout", $signed(dout), 0);
    chk("reset_valid", dout_valid, 0);
    chk("reset_level", fifo_level, 0);
    chk("reset_sat", sat_flag, 0);
    mon_en = 1'b1;

    // Basic average: 10,20,30,41 -> 25
    step(1, 10); step(1, 20); step(1, 30); step(1, 41);
    idle(1);
    chk("avg_valid", dout_valid, 1);
    chk("avg_dout", $signed(dout), 25);
    chk("avg_sat", sat_flag, 0);
    idle(2);

    // Negative rounding and saturation both ways
    step(1, -10); step(1, -10); step(1, -10); step(1, -11);
    idle(1);
    chk("neg_dout", $signed(dout), -10);
    idle(1);
    block4(32'h7FFF_FFFF);
    idle(1);
    chk("sat_hi_dout", $signed(dout), 32767);
    chk("sat_hi_flag", sat_flag, 1);
    idle(1);
    block4(32'h8000_0000);
    idle(1);
    chk("sat_lo_dout", $signed(dout), -32768);
    clr_flags = 1'b1; idle(1); clr_flags = 1'b0;
    chk("sat_clr", sat_flag, 0);
    idle(1);

    // Fill FIFO with ready low, fifth result dropped, then drain
    dout_ready = 1'b0;
    for (int i = 0; i < 20; i++) step(1, 4);
    idle(2);
    chk("full_level", fifo_level, 4);
    chk("full_ovf", ovf_flag, 1);
`ifdef FOS_DECIM_DROP_CNT_EN
    chk("full_drop_cnt", drop_cnt, 1);
`endif
    dout_ready = 1'b1;
    idle(6);
    chk("drained_level", fifo_level, 0);

    // Simultaneous push and pop while full
    clr_flags = 1'b1; idle(1); clr_flags = 1'b0;
    dout_ready = 1'b0;
    for (int i = 0; i < 16; i++) step(1, 4);
    idle(2);
    block4(8);
    dout_ready = 1'b1;
    idle(1);
    dout_ready = 1'b0;
    chk("pushpop_level", fifo_level, 4);
    chk("pushpop_ovf", ovf_flag, 0);
    idle(1);
    dout_ready = 1'b1;
    idle(6);

    // Gapped in_en: only enabled edges count
    step(1, 100); step(0, $urandom); step(0, $urandom); step(1, 100);
    step(1, 100); step(0, $urandom); step(1, 100);
    idle(1);
    chk("gap_valid", dout_valid, 1);
    chk("gap_dout", $signed(dout), 100);
    idle(3);

    // Reset mid-block discards the partial sum
    step(1, 1000); step(1, 1000);
    reset = 1'b0; idle(1); reset = 1'b1;
    block4(4);
    idle(1);
    chk("rst_mid_level", fifo_level, 1);
    chk("rst_mid_dout", $signed(dout), 4);
    chk("rst_mid_flags", {sat_flag, ovf_flag}, 0);
    idle(3);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [31:0] y;
      reset      = ($urandom_range(0, 199) != 0);
      dout_ready = ($urandom_range(0, 9) < 6);
      clr_flags  = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0) y = $urandom;
      else y = 32'($signed($urandom_range(0, 2000)) - 1000);
      step($urandom_range(0, 9) < 7, y);
    end
    reset = 1'b1; clr_flags = 1'b0; dout_ready = 1'b1;
    idle(10);
    chk("scoreboard_empty", exp_q.size(), 0);
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
